// File: rtl/pe_pkg.sv
// Shared definitions for the systolic processing element.
//   DEF_DATA_WIDTH / DEF_ACC_WIDTH : default operand and accumulator widths
//   bound_t                        : wide signed container for saturation bounds
//   acc_max(width) / acc_min(width): largest / smallest signed value of a
//                                    width-bit accumulator, sign-extended
//                                    into bound_t. Callers keep the low
//                                    'width' bits.
package pe_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 64;
    localparam int BOUND_W        = 256;

    typedef logic signed [BOUND_W-1:0] bound_t;

    function automatic bound_t acc_max(input int width);
        bound_t r;
        r = '0;
        r[width-1] = 1'b1;
        return r - bound_t'(1);
    endfunction

    // The most negative value is the bitwise complement of the most positive one.
    function automatic bound_t acc_min(input int width);
        return ~acc_max(width);
    endfunction

endpackage

// File: rtl/pe_sat_adder.sv
// Combinational signed accumulator adder with overflow detection.
//   acc    : current accumulator value (signed, ACC_WIDTH)
//   p      : sign-extended product to add (signed, ACC_WIDTH)
//   sat_en : 1 = clamp to the signed range on overflow, 0 = wrap
//   result : acc + p, clamped when sat_en is set and the add overflowed
//   ovf    : the add overflowed the signed ACC_WIDTH range
module pe_sat_adder
    import pe_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [ACC_WIDTH-1:0] p,
    input  logic                        sat_en,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic                        ovf
);

    localparam bound_t MAX_FULL = acc_max(ACC_WIDTH);
    localparam bound_t MIN_FULL = acc_min(ACC_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] MAX_VAL = MAX_FULL[ACC_WIDTH-1:0];
    localparam logic signed [ACC_WIDTH-1:0] MIN_VAL = MIN_FULL[ACC_WIDTH-1:0];

    logic signed [ACC_WIDTH-1:0] sum;

    always_comb begin
        sum = acc + p;
        // Overflow only when both addends share a sign and the sum does not.
        ovf = (acc[ACC_WIDTH-1] == p[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        result = sum;
        if (ovf && sat_en) begin
            result = p[ACC_WIDTH-1] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/pe_mac_pipe.sv
// Systolic processing element: forwards operands east/south with one cycle
// of latency and accumulates a framed signed dot product over a two-stage
// multiply/accumulate pipeline.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   valid_i, first_i, last_i     : operand-pair valid and frame markers
//   a_i, b_i                     : signed operands
//   a_o, b_o                     : registered operands (load on valid_i)
//   valid_o, first_o, last_o     : registered valid and qualified markers
//   res_o, overflow_o            : last completed dot product and its
//                                  sticky overflow flag (held between strobes)
//   res_valid_o                  : one-cycle strobe when res_o is updated
module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SAT_EN     = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic                         first_i,
    input  logic                         last_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic signed [DATA_WIDTH-1:0] b_o,
    output logic                         valid_o,
    output logic                         first_o,
    output logic                         last_o,
    output logic signed [ACC_WIDTH-1:0]  res_o,
    output logic                         res_valid_o,
    output logic                         overflow_o
);

    localparam int   PROD_W = 2 * DATA_WIDTH;
    localparam logic SAT_ON = (SAT_EN != 0);

    if (ACC_WIDTH < PROD_W) begin : g_bad_width
        $error("pe_mac_pipe: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    // Forwarding registers. valid_q/first_q/last_q double as the stage-1
    // framing (v1/f1/l1), since they carry exactly the same information.
    logic signed [DATA_WIDTH-1:0] a_q, a_d;
    logic signed [DATA_WIDTH-1:0] b_q, b_d;
    logic                         valid_q, valid_d;
    logic                         first_q, first_d;
    logic                         last_q, last_d;

    // Stage 1: registered product, sign-extended to the accumulator width.
    logic signed [ACC_WIDTH-1:0]  p1_q, p1_d;

    // Stage 2: running accumulator and the published result.
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         ovf_q, ovf_d;
    logic signed [ACC_WIDTH-1:0]  res_q, res_d;
    logic                         res_ovf_q, res_ovf_d;
    logic                         res_valid_q, res_valid_d;

    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_WIDTH-1:0]  add_res;
    logic                         add_ovf;
    logic signed [ACC_WIDTH-1:0]  acc_new;
    logic                         ovf_new;

    pe_sat_adder #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_adder (
        .acc    (acc_q),
        .p      (p1_q),
        .sat_en (SAT_ON),
        .result (add_res),
        .ovf    (add_ovf)
    );

    always_comb begin
        // Forwarding / stage 1
        a_d     = a_q;
        b_d     = b_q;
        p1_d    = p1_q;
        valid_d = valid_i;
        first_d = first_i & valid_i;
        last_d  = last_i & valid_i;
        prod    = $signed(PROD_W'(a_i)) * $signed(PROD_W'(b_i));
        if (valid_i) begin
            a_d  = a_i;
            b_d  = b_i;
            p1_d = $signed(ACC_WIDTH'(prod));
        end

        // Stage 2: a first element restarts the accumulator and clears the
        // sticky flag; any other element adds onto whatever acc holds.
        acc_new = first_q ? p1_q : add_res;
        ovf_new = first_q ? 1'b0 : (ovf_q | add_ovf);

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        res_d       = res_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = 1'b0;
        if (valid_q) begin
            acc_d = acc_new;
            ovf_d = ovf_new;
            if (last_q) begin
                res_d       = acc_new;
                res_ovf_d   = ovf_new;
                res_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q         <= '0;
            b_q         <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            p1_q        <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            res_q       <= '0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            p1_q        <= p1_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            res_q       <= res_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign valid_o     = valid_q;
    assign first_o     = first_q;
    assign last_o      = last_q;
    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign overflow_o  = res_ovf_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Bench for pe_mac_pipe: a wrapping and a saturating 8/16 instance share one
// stimulus stream; a default-width 32/64 instance has its own.
module tb_pe_mac_pipe;

    localparam int DW = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // shared narrow stimulus
    logic valid, first, last;
    logic signed [DW-1:0] a, b;

    // wrapping instance
    logic signed [DW-1:0] w_a_o, w_b_o;
    logic w_valid_o, w_first_o, w_last_o, w_rv, w_ovf;
    logic signed [AW-1:0] w_res;
    // saturating instance
    logic signed [DW-1:0] s_a_o, s_b_o;
    logic s_valid_o, s_first_o, s_last_o, s_rv, s_ovf;
    logic signed [AW-1:0] s_res;
    // default-width instance
    logic bv, bf, bl;
    logic signed [31:0] ba, bb, g_a_o, g_b_o;
    logic g_valid_o, g_first_o, g_last_o, g_rv, g_ovf;
    logic signed [63:0] g_res;

    pe_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SAT_EN(0)) u_wrap (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid), .first_i(first), .last_i(last),
        .a_i(a), .b_i(b), .a_o(w_a_o), .b_o(w_b_o), .valid_o(w_valid_o),
        .first_o(w_first_o), .last_o(w_last_o), .res_o(w_res),
        .res_valid_o(w_rv), .overflow_o(w_ovf));

    pe_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SAT_EN(1)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid), .first_i(first), .last_i(last),
        .a_i(a), .b_i(b), .a_o(s_a_o), .b_o(s_b_o), .valid_o(s_valid_o),
        .first_o(s_first_o), .last_o(s_last_o), .res_o(s_res),
        .res_valid_o(s_rv), .overflow_o(s_ovf));

    pe_mac_pipe u_big (
        .clk_i(clk), .rst_i(rst_i), .valid_i(bv), .first_i(bf), .last_i(bl),
        .a_i(ba), .b_i(bb), .a_o(g_a_o), .b_o(g_b_o), .valid_o(g_valid_o),
        .first_o(g_first_o), .last_o(g_last_o), .res_o(g_res),
        .res_valid_o(g_rv), .overflow_o(g_ovf));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard and reference model ----------------
    typedef struct {
        int cyc;
        int res_w;
        bit ovf_w;
        int res_s;
        bit ovf_s;
    } exp_t;
    exp_t sb[$];

    int m_acc_w, m_acc_s;
    bit m_ovf_w, m_ovf_s;

    function automatic int wrap16(input int t);
        logic signed [15:0] w;
        w = t[15:0];
        return int'(w);
    endfunction

    task automatic model_reset();
        m_acc_w = 0; m_acc_s = 0; m_ovf_w = 0; m_ovf_s = 0;
        sb.delete();
    endtask

    task automatic send(input bit f, input bit l, input int av, input int bw);
        int p, t;
        exp_t e;
        @(posedge clk);
        #1;
        valid = 1'b1; first = f; last = l; a = 8'(av); b = 8'(bw);
        p = av * bw;
        if (f) begin
            m_acc_w = p; m_acc_s = p; m_ovf_w = 0; m_ovf_s = 0;
        end else begin
            t = m_acc_w + p;
            if (t > 32767 || t < -32768) m_ovf_w = 1;
            m_acc_w = wrap16(t);
            t = m_acc_s + p;
            if (t > 32767) begin m_ovf_s = 1; m_acc_s = 32767; end
            else if (t < -32768) begin m_ovf_s = 1; m_acc_s = -32768; end
            else m_acc_s = t;
        end
        if (l) begin
            e.cyc = cyc + 2;
            e.res_w = m_acc_w; e.ovf_w = m_ovf_w;
            e.res_s = m_acc_s; e.ovf_s = m_ovf_s;
            sb.push_back(e);
        end
    endtask

    // Idle cycles with random operands; junk=1 also raises first/last without valid.
    task automatic idle(input int n, input bit junk = 1'b0);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid = 1'b0; first = junk; last = junk;
            a = 8'($urandom); b = 8'($urandom);
        end
    endtask

    // forwarding expectation
    logic signed [DW-1:0] fa, fb;
    logic fv, ff, fl;
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            fa <= '0; fb <= '0; fv <= 1'b0; ff <= 1'b0; fl <= 1'b0;
        end else begin
            fv <= valid; ff <= first & valid; fl <= last & valid;
            if (valid) begin fa <= a; fb <= b; end
        end
    end

    // ---------------- monitor ----------------
    int hold_w = 0, hold_s = 0;
    bit hold_ow = 0, hold_os = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            hold_w = 0; hold_s = 0; hold_ow = 0; hold_os = 0;
        end
        chk("fwd_valid", 64'(w_valid_o), 64'(fv));
        chk("fwd_first", 64'(w_first_o), 64'(ff));
        chk("fwd_last", 64'(w_last_o), 64'(fl));
        chk("fwd_a", 64'(w_a_o), 64'(fa));
        chk("fwd_b", 64'(w_b_o), 64'(fb));
        chk("sat_valid_o", 64'(s_valid_o), 64'(fv));
        chk("rv_sat_vs_wrap", 64'(s_rv), 64'(w_rv));
        if (w_rv) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                chk("res_wrap", 64'(w_res), 64'(e.res_w));
                chk("ovf_wrap", 64'(w_ovf), 64'(e.ovf_w));
                chk("res_sat", 64'(s_res), 64'(e.res_s));
                chk("ovf_sat", 64'(s_ovf), 64'(e.ovf_s));
                hold_w = e.res_w; hold_ow = e.ovf_w;
                hold_s = e.res_s; hold_os = e.ovf_s;
            end
        end else begin
            chk("hold_res_wrap", 64'(w_res), 64'(hold_w));
            chk("hold_ovf_wrap", 64'(w_ovf), 64'(hold_ow));
            chk("hold_res_sat", 64'(s_res), 64'(hold_s));
            chk("hold_ovf_sat", 64'(s_ovf), 64'(hold_os));
        end
    end

    // ---------------- default-width instance helpers ----------------
    task automatic big_send(input bit f, input bit l, input logic [31:0] av, input logic [31:0] bw);
        @(posedge clk);
        #1;
        bv = 1'b1; bf = f; bl = l; ba = av; bb = bw;
    endtask

    task automatic big_wait(input string tag, input logic [63:0] exp_res, input bit exp_ovf);
        int n;
        bit seen;
        @(posedge clk);
        #1;
        bv = 1'b0; bf = 1'b0; bl = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (g_rv) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(n), 64'(2));
        chk({tag, "_res"}, g_res, exp_res);
        chk({tag, "_ovf"}, 64'(g_ovf), 64'(exp_ovf));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b1;
        valid = 1'b0; first = 1'b0; last = 1'b0; a = '0; b = '0;
        bv = 1'b0; bf = 1'b0; bl = 1'b0; ba = '0; bb = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_res", 64'(w_res), 64'(0));
        chk("rst_rv", 64'(w_rv), 64'(0));
        chk("rst_big_res", g_res, 64'(0));
        @(posedge clk);
        #3 rst_i = 1'b0;

        // basic dot product: 12 - 10 - 7 = -5
        send(1, 0, 3, 4);
        send(0, 0, -2, 5);
        send(0, 1, 7, -1);
        idle(4);

        // accumulate overflow, then a single-element frame right after
        send(1, 0, 127, 127);
        send(0, 0, 127, 127);
        send(0, 1, 127, 127);
        send(1, 1, 2, 3);
        idle(3);

        // negative-direction overflow
        send(1, 0, -128, 127);
        send(0, 0, -128, 127);
        send(0, 1, -128, 127);
        idle(3);

        // bubbles inside a frame, then a back-to-back single-element frame
        send(1, 0, 1, 1);
        idle(2);
        send(0, 1, 2, 2);
        send(1, 1, 5, 5);
        idle(3);

        // element without first continues the accumulator (25 + 3 = 28)
        send(0, 1, 1, 3);
        // markers without valid must be ignored
        idle(3, 1'b1);
        idle(3);

        // asynchronous reset with elements in flight
        send(1, 0, 3, 3);
        send(0, 0, 2, 2);
        @(posedge clk);
        #1;
        valid = 1'b0; first = 1'b0; last = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        chk("arst_valid_o", 64'(w_valid_o), 64'(0));
        chk("arst_a_o", 64'(w_a_o), 64'(0));
        chk("arst_b_o", 64'(w_b_o), 64'(0));
        chk("arst_res", 64'(w_res), 64'(0));
        chk("arst_ovf", 64'(w_ovf), 64'(0));
        chk("arst_rv", 64'(w_rv), 64'(0));
        @(posedge clk);
        #3 rst_i = 1'b0;
        idle(4);
        send(1, 0, 4, 4);
        send(0, 1, 1, -1);
        idle(4);

        // default widths: (-2^31)^2 = 2^62, and two of them overflow to -2^63
        big_send(1, 1, 32'h8000_0000, 32'h8000_0000);
        big_wait("big_single", 64'h4000_0000_0000_0000, 1'b0);
        big_send(1, 0, 32'h8000_0000, 32'h8000_0000);
        big_send(0, 1, 32'h8000_0000, 32'h8000_0000);
        big_wait("big_wrap", 64'h8000_0000_0000_0000, 1'b1);

        idle(4);
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
